// File: rtl/demux13_5_reg.sv
// -----------------------------------------------------------------------------
// demux13_5_reg
// Write-side counterpart of the 5:1 datapath muxes. It steers one source word
// into one of five depth-1 holding registers, chosen by a 3-bit selector.
// Each slot has a valid flag and a consumer acknowledge. The source side
// back-pressures the producer while the chosen slot is full.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous reset, active low
//   in_valid / in_ready     producer handshake (in_ready is combinational)
//   selector [2:0]          destination code; 0..4 select slots 0..4
//   data_in [DATA_W-1:0]    word to dispatch
//   out_ack [4:0]           per-slot consumer acknowledge
//   out_valid [4:0]         per-slot "holds an unconsumed word" flag
//   data_out_0..4           per-slot holding registers
//   xfer_count [CNT_W-1:0]  accepted words since reset; wraps silently
//   sel_err                 sticky illegal-selector flag
//
// Configuration macro: DEMUX_SEL_ERR_EN
//   undefined : selectors 5..7 act as selector 0, and sel_err is tied to 0
//   defined   : selectors 5..7 are accepted and dropped, and sel_err is set
//
// Handshake: a word transfers on a rising edge when in_valid && in_ready.
// The producer holds data_in and selector stable until that edge. An out_ack
// in the same cycle frees its slot, so the slot can take a new word that cycle.
// -----------------------------------------------------------------------------
module demux13_5_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        selector,
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        out_ack,
  output logic [4:0]        out_valid,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic [DATA_W-1:0] data_out_4,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              sel_err
);

  logic              sel_legal;
  logic              drop;
  logic [2:0]        eff_sel;
  logic [4:0]        sel_oh;
  logic              accept;
  logic [4:0]        load;
  logic [4:0]        valid_d;
  logic [DATA_W-1:0] slot_q [5];

  assign sel_legal = (selector <= 3'd4);

`ifdef DEMUX_SEL_ERR_EN
  // An illegal code is accepted and dropped, so the producer never stalls on it.
  assign drop = ~sel_legal;
`else
  assign drop = 1'b0;
`endif

  // Out-of-range codes fold onto slot 0. This matches the mux default arm.
  assign eff_sel  = sel_legal ? selector : 3'd0;
  assign sel_oh   = 5'b00001 << eff_sel;
  assign in_ready = drop | (|(sel_oh & (~out_valid | out_ack)));
  assign accept   = in_valid & in_ready & ~drop;
  assign load     = accept ? sel_oh : 5'b00000;

  // A load wins over an ack on the same slot, so the slot stays valid.
  // An ack on an empty slot clears a bit that is already 0.
  assign valid_d = load | (out_valid & ~out_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= '0;
      xfer_count <= '0;
      for (int k = 0; k < 5; k++) slot_q[k] <= '0;
    end else begin
      out_valid <= valid_d;
      if (accept) xfer_count <= xfer_count + 1'b1;
      // data_out is not cleared on ack. Only a new load overwrites it.
      for (int k = 0; k < 5; k++) begin
        if (load[k]) slot_q[k] <= data_in;
      end
    end
  end

`ifdef DEMUX_SEL_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      sel_err <= 1'b0;
    else if (in_valid && !sel_legal) sel_err <= 1'b1;
  end
`else
  assign sel_err = 1'b0;
`endif

  assign data_out_0 = slot_q[0];
  assign data_out_1 = slot_q[1];
  assign data_out_2 = slot_q[2];
  assign data_out_3 = slot_q[3];
  assign data_out_4 = slot_q[4];

endmodule

// File: tb/tb_demux13_5_reg.sv
// -----------------------------------------------------------------------------
// tb_demux13_5_reg
// Self-checking bench for demux13_5_reg. It is built with CNT_W=4 so that the
// counter wrap is reached in 16 accepts. A behavioural model tracks slot
// valid flags, slot contents, the counter and sel_err. Accepted words go into
// exp_q/exp_slot_q and are popped and compared once the slot shows them.
// The bench honours DEMUX_SEL_ERR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_demux13_5_reg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        selector;
  logic [DATA_W-1:0] data_in;
  logic [4:0]        out_ack;
  logic [4:0]        out_valid;
  logic [DATA_W-1:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [CNT_W-1:0]  xfer_count;
  logic              sel_err;

  demux13_5_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .data_in(data_in), .out_ack(out_ack),
    .out_valid(out_valid), .data_out_0(data_out_0), .data_out_1(data_out_1),
    .data_out_2(data_out_2), .data_out_3(data_out_3), .data_out_4(data_out_4),
    .xfer_count(xfer_count), .sel_err(sel_err)
  );

  // ---------------- scoreboard / model state ----------------
  int                n_cmp  = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_slot_q[$];
  logic [4:0]        m_valid;
  logic [CNT_W-1:0]  m_count;
  logic              m_err;
  logic [DATA_W-1:0] m_data [5];
  logic              exp_ready, obs_ready;

  function automatic logic [DATA_W-1:0] dout(input int k);
    case (k)
      0: return data_out_0;
      1: return data_out_1;
      2: return data_out_2;
      3: return data_out_3;
      default: return data_out_4;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = '0; m_count = '0; m_err = 1'b0;
    for (int k = 0; k < 5; k++) m_data[k] = '0;
    exp_q.delete(); exp_slot_q.delete();
  endtask

  // ---------------- driver ----------------
  // Call at a falling edge. The task drives for one cycle and samples in_ready
  // before the rising edge. It returns at the next falling edge with the model
  // updated.
  task automatic drive(input logic v, input logic [2:0] sel,
                       input logic [DATA_W-1:0] d, input logic [4:0] ack);
    int   es;
    logic legal, acc;
    in_valid = v; selector = sel; data_in = d; out_ack = ack;
    legal = (sel <= 3'd4);
    es = legal ? int'(sel) : 0;
    exp_ready = !m_valid[es] || ack[es];
`ifdef DEMUX_SEL_ERR_EN
    if (!legal) begin
      exp_ready = 1'b1;
      if (v) m_err = 1'b1;
    end
    acc = v && exp_ready && legal;
`else
    acc = v && exp_ready;
`endif
    #1 obs_ready = in_ready;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      if (acc && es == k) m_valid[k] = 1'b1;
      else if (ack[k])    m_valid[k] = 1'b0;
    end
    if (acc) begin
      m_data[es] = d;
      m_count    = m_count + 1'b1;
      exp_q.push_back(d);
      exp_slot_q.push_back(es);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; out_ack = '0; selector = '0; data_in = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b1, 3'd1, 32'hAAAA_0001, 5'b0);
    drive(1'b1, 3'd2, 32'hAAAA_0002, 5'b0);
    exp_q.delete(); exp_slot_q.delete();
    // Assert reset between clock edges while traffic is still on the bus.
    in_valid = 1'b1; selector = 3'd0; data_in = 32'h5555_5555;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 00000", out_valid); end
    n_cmp++; if (xfer_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", xfer_count); end
    n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b exp 0", sel_err); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (dout(k) !== '0) begin n_fail++; $display("FAIL reset_data%0d: got %h exp 0", k, dout(k)); end
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    drive(1'b0, 3'd0, '0, 5'b0);
    n_cmp++; if (out_valid !== 5'b0) begin n_fail++; $display("FAIL reset_hold: got %b exp 00000", out_valid); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] d; int s;
    drive(1'b1, 3'd3, 32'hDEADBEEF, 5'b0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b exp 1", obs_ready); end
    n_cmp++; if (out_valid !== 5'b01000) begin n_fail++; $display("FAIL basic_valid: got %b exp 01000", out_valid); end
    n_cmp++; if (xfer_count !== 4'd1) begin n_fail++; $display("FAIL basic_count: got %0d exp 1", xfer_count); end
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front(); s = exp_slot_q.pop_front();
      n_cmp++; if (dout(s) !== d) begin n_fail++; $display("FAIL basic_data%0d: got %h exp %h", s, dout(s), d); end
    end
    drive(1'b0, 3'd0, '0, 5'b01000);
    n_cmp++; if (out_valid !== 5'b0) begin n_fail++; $display("FAIL basic_ack: got %b exp 00000", out_valid); end
    n_cmp++; if (data_out_3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_keep: got %h exp deadbeef", data_out_3); end
  endtask

  task automatic test_back_pressure();
    logic [DATA_W-1:0] d; int s; logic [CNT_W-1:0] c0;
    drive(1'b1, 3'd2, 32'h2222_0001, 5'b0);
    exp_q.delete(); exp_slot_q.delete();
    c0 = xfer_count;
    drive(1'b1, 3'd2, 32'h2222_0002, 5'b0);
    n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b exp 0", obs_ready); end
    n_cmp++; if (data_out_2 !== 32'h2222_0001) begin n_fail++; $display("FAIL bp_hold: got %h exp 22220001", data_out_2); end
    n_cmp++; if (xfer_count !== c0) begin n_fail++; $display("FAIL bp_count: got %0d exp %0d", xfer_count, c0); end
    drive(1'b1, 3'd2, 32'h2222_0002, 5'b00100);
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ack_ready: got %b exp 1", obs_ready); end
    n_cmp++; if (out_valid[2] !== 1'b1) begin n_fail++; $display("FAIL bp_ack_valid: got %b exp 1", out_valid[2]); end
    n_cmp++; if (xfer_count !== c0 + 1'b1) begin n_fail++; $display("FAIL bp_ack_count: got %0d exp %0d", xfer_count, c0 + 1'b1); end
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front(); s = exp_slot_q.pop_front();
      n_cmp++; if (dout(s) !== d) begin n_fail++; $display("FAIL bp_data%0d: got %h exp %h", s, dout(s), d); end
    end
    drive(1'b0, 3'd0, '0, 5'b00100);
  endtask

  task automatic test_parallel();
    logic [DATA_W-1:0] d; int s;
    drive(1'b1, 3'd0, 32'h0000_1000 | $urandom_range(0, 4095), 5'b0);
    drive(1'b1, 3'd1, 32'h0000_2000 | $urandom_range(0, 4095), 5'b0);
    drive(1'b1, 3'd4, 32'h0000_4000 | $urandom_range(0, 4095), 5'b0);
    n_cmp++; if (out_valid !== 5'b10011) begin n_fail++; $display("FAIL par_fill: got %b exp 10011", out_valid); end
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front(); s = exp_slot_q.pop_front();
      n_cmp++; if (dout(s) !== d) begin n_fail++; $display("FAIL par_data%0d: got %h exp %h", s, dout(s), d); end
    end
    drive(1'b0, 3'd0, '0, 5'b10001);
    n_cmp++; if (out_valid !== 5'b00010) begin n_fail++; $display("FAIL par_ack: got %b exp 00010", out_valid); end
    n_cmp++; if (data_out_0 !== m_data[0]) begin n_fail++; $display("FAIL par_keep0: got %h exp %h", data_out_0, m_data[0]); end
    n_cmp++; if (data_out_4 !== m_data[4]) begin n_fail++; $display("FAIL par_keep4: got %h exp %h", data_out_4, m_data[4]); end
    drive(1'b0, 3'd0, '0, 5'b00010);
  endtask

  task automatic test_illegal_sel();
    logic [CNT_W-1:0] c0; logic [4:0] v0;
    c0 = xfer_count; v0 = out_valid;
    drive(1'b1, 3'd6, 32'h0000_1234, 5'b0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b exp 1", obs_ready); end
`ifdef DEMUX_SEL_ERR_EN
    n_cmp++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL ill_sel_err: got %b exp 1", sel_err); end
    n_cmp++; if (xfer_count !== c0) begin n_fail++; $display("FAIL ill_count: got %0d exp %0d", xfer_count, c0); end
    n_cmp++; if (out_valid !== v0) begin n_fail++; $display("FAIL ill_valid: got %b exp %b", out_valid, v0); end
`else
    n_cmp++; if (data_out_0 !== 32'h0000_1234) begin n_fail++; $display("FAIL ill_data0: got %h exp 00001234", data_out_0); end
    n_cmp++; if (out_valid !== (v0 | 5'b00001)) begin n_fail++; $display("FAIL ill_valid: got %b exp %b", out_valid, v0 | 5'b00001); end
    n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL ill_sel_err: got %b exp 0", sel_err); end
`endif
    exp_q.delete(); exp_slot_q.delete();
    drive(1'b0, 3'd0, '0, 5'b11111);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'(i % 5), $urandom, 5'b00001 << (i % 5));
    end
    n_cmp++; if (xfer_count !== 4'd0) begin n_fail++; $display("FAIL wrap_count: got %0d exp 0", xfer_count); end
    exp_q.delete(); exp_slot_q.delete();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d; int s;
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)));
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b exp %b", i, obs_ready, exp_ready); end
      n_cmp++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b exp %b", i, out_valid, m_valid); end
      n_cmp++; if (xfer_count !== m_count) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d exp %0d", i, xfer_count, m_count); end
      n_cmp++; if (sel_err !== m_err) begin n_fail++; $display("FAIL rnd_sel_err@%0d: got %b exp %b", i, sel_err, m_err); end
      while (exp_q.size() > 0) begin
        d = exp_q.pop_front(); s = exp_slot_q.pop_front();
        n_cmp++; if (dout(s) !== d) begin n_fail++; $display("FAIL rnd_data%0d@%0d: got %h exp %h", s, i, dout(s), d); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b0; in_valid = 1'b0; selector = '0; data_in = '0; out_ack = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_basic();
    test_back_pressure();
    test_parallel();
    test_illegal_sel();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
